// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-port arbiter (loader, data, fetch) onto one single-ported memory
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch (read-only)
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // CPU data (read/write)
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // boot/debug loader (write-only)
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    // memory macro pins
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    // Winner / read-owner encoding
    localparam logic [1:0] W_NONE = 2'd0;
    localparam logic [1:0] W_IF   = 2'd1;
    localparam logic [1:0] W_D    = 2'd2;
    localparam logic [1:0] W_LD   = 2'd3;

    logic              r_if_gnt;
    logic              r_d_gnt;
    logic              r_ld_gnt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [1:0]        r_rd_tag;
    logic              r_if_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_if_elig;
    logic              w_d_elig;
    logic              w_ld_elig;
    logic              w_if_promoted;
    logic [1:0]        w_win;
    logic              w_issue_re;
    logic              w_issue_we;

    // A port whose grant is showing this cycle is already served; its held req must not win again
    assign w_if_elig     = if_req & ~r_if_gnt;
    assign w_d_elig      = d_req  & ~r_d_gnt;
    assign w_ld_elig     = ld_req & ~r_ld_gnt;
    assign w_if_promoted = (r_starve_cnt >= CNT_MAX);

    // Fixed priority ld > d > if, with fetch lifted above data once it has starved long enough
    always_comb begin
        w_win = W_NONE;
        if (w_ld_elig) begin
            w_win = W_LD;
        end else if (w_if_elig && w_if_promoted) begin
            w_win = W_IF;
        end else if (w_d_elig) begin
            w_win = W_D;
        end else if (w_if_elig) begin
            w_win = W_IF;
        end
    end

    assign w_issue_re = (w_win == W_IF) || ((w_win == W_D) && !d_we);
    assign w_issue_we = (w_win == W_LD) || ((w_win == W_D) && d_we);

    // Register the winning command onto the memory pins together with its grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_ld_gnt    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_if_gnt <= (w_win == W_IF);
            r_d_gnt  <= (w_win == W_D);
            r_ld_gnt <= (w_win == W_LD);
            r_mem_re <= w_issue_re;
            r_mem_we <= w_issue_we;
            case (w_win)
                W_IF: begin
                    r_mem_addr <= if_addr;
                end
                W_D: begin
                    r_mem_addr <= d_addr;
                    if (d_we) begin
                        r_mem_wdata <= d_wdata;
                    end
                end
                W_LD: begin
                    r_mem_addr  <= ld_addr;
                    r_mem_wdata <= ld_wdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Count cycles fetch was eligible but lost; saturate so promotion persists until fetch wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if ((w_win == W_IF) || !if_req) begin
            r_starve_cnt <= '0;
        end else if (w_if_elig && (r_starve_cnt < CNT_MAX)) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    // Single outstanding read: tag the owner at issue, turn it into rvalid one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_tag    <= W_NONE;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
        end else begin
            r_rd_tag    <= w_issue_re ? w_win : W_NONE;
            r_if_rvalid <= (r_rd_tag == W_IF);
            r_d_rvalid  <= (r_rd_tag == W_D);
        end
    end

    // Capture returned data so each port's rdata holds until its next rvalid
    always_ff @(posedge clk) begin
        if (rst) begin
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
        end else begin
            if (r_if_rvalid) begin
                r_if_rdata <= mem_rdata;
            end
            if (r_d_rvalid) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign if_gnt    = r_if_gnt;
    assign d_gnt     = r_d_gnt;
    assign ld_gnt    = r_ld_gnt;
    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    // Memory data is live in the rvalid cycle; afterwards the captured copy is shown
    assign if_rdata  = r_if_rvalid ? mem_rdata : r_if_rdata;
    assign d_rdata   = r_d_rvalid  ? mem_rdata : r_d_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory macro: write at edge, read data valid the next cycle
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    // Reference model state (expected outputs for the current cycle)
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic          m_gnt_if = 0, m_gnt_d = 0, m_gnt_ld = 0;
    logic          m_re = 0, m_we = 0, m_rv_if = 0, m_rv_d = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rd_if = '0, m_rd_d = '0, p_data = '0;
    int            m_starve = 0;
    int            p_owner = 0;   // 0 none, 1 fetch, 2 data

    int n_pass = 0;
    int n_total = 0;

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a] <= v;
        ref_mem[a] = v;
    endtask

    // Advance model by one cycle from current inputs, then advance the clock
    task automatic tick();
        int   win;
        logic e_if, e_d, e_ld;
        if (rst) begin
            m_gnt_if = 0; m_gnt_d = 0; m_gnt_ld = 0;
            m_re = 0; m_we = 0; m_rv_if = 0; m_rv_d = 0;
            m_addr = '0; m_wdata = '0; m_rd_if = '0; m_rd_d = '0;
            m_starve = 0; p_owner = 0;
        end else begin
            e_if = if_req && !m_gnt_if;
            e_d  = d_req  && !m_gnt_d;
            e_ld = ld_req && !m_gnt_ld;
            m_rv_if = (p_owner == 1);
            m_rv_d  = (p_owner == 2);
            if (m_rv_if) m_rd_if = p_data;
            if (m_rv_d)  m_rd_d  = p_data;
            p_owner = 0;
            if (e_ld)                      win = 3;
            else if (e_if && m_starve >= SL) win = 1;
            else if (e_d)                  win = 2;
            else if (e_if)                 win = 1;
            else                           win = 0;
            m_gnt_if = (win == 1); m_gnt_d = (win == 2); m_gnt_ld = (win == 3);
            m_re = 0; m_we = 0;
            if (win == 1) begin
                m_re = 1; m_addr = if_addr; p_owner = 1; p_data = ref_mem[if_addr];
            end else if (win == 2) begin
                m_addr = d_addr;
                if (d_we) begin
                    m_we = 1; m_wdata = d_wdata; ref_mem[d_addr] = d_wdata;
                end else begin
                    m_re = 1; p_owner = 2; p_data = ref_mem[d_addr];
                end
            end else if (win == 3) begin
                m_we = 1; m_addr = ld_addr; m_wdata = ld_wdata; ref_mem[ld_addr] = ld_wdata;
            end
            if (win == 1 || !if_req)      m_starve = 0;
            else if (e_if && m_starve < SL) m_starve = m_starve + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; if_req = 0; d_req = 0; ld_req = 0; d_we = 0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1;
        if_req = 1; if_addr = 12'h002;
        d_req = 1;  d_we = 0; d_addr = 12'h001; d_wdata = 32'h1111_2222;
        ld_req = 1; ld_addr = 12'h3FF; ld_wdata = 32'hA0A0_3FFF;
        tick(); tick();
        n_total++;
        if ({if_gnt, d_gnt, ld_gnt, mem_re, mem_we, if_rvalid, d_rvalid} !== 7'b0)
            $display("FAIL reset_ctrl: got %b expected 0000000", {if_gnt, d_gnt, ld_gnt, mem_re, mem_we, if_rvalid, d_rvalid});
        else n_pass++;
        n_total++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_data: got %h/%h/%h/%h expected all 0", if_rdata, d_rdata, mem_addr, mem_wdata);
        else n_pass++;
        rst = 0;
        tick();
        n_total++;
        if ({ld_gnt, d_gnt, if_gnt, mem_we, mem_addr} !== {4'b1001, 12'h3FF})
            $display("FAIL reset_first_ld: got ld=%b d=%b if=%b we=%b addr=%h expected ld only, we, 3ff", ld_gnt, d_gnt, if_gnt, mem_we, mem_addr);
        else n_pass++;
        ld_req = 0;
        tick();
        n_total++;
        if ({ld_gnt, d_gnt, if_gnt} !== 3'b010)
            $display("FAIL reset_second_d: got ld/d/if=%b expected 010", {ld_gnt, d_gnt, if_gnt});
        else n_pass++;
        idle();
    endtask

    task automatic test_single_fetch();
        preload(12'h010, 32'hDEAD_BEEF);
        if_req = 1; if_addr = 12'h010;
        tick();
        n_total++;
        if ({if_gnt, mem_re, mem_we, mem_addr} !== {3'b110, 12'h010})
            $display("FAIL fetch_issue: got gnt=%b re=%b we=%b addr=%h expected 1 1 0 010", if_gnt, mem_re, mem_we, mem_addr);
        else n_pass++;
        if_req = 0;
        tick();
        n_total++;
        if ({if_rvalid, if_gnt, if_rdata} !== {2'b10, 32'hDEAD_BEEF})
            $display("FAIL fetch_return: got rvalid=%b gnt=%b rdata=%h expected 1 0 deadbeef", if_rvalid, if_gnt, if_rdata);
        else n_pass++;
        tick();
        n_total++;
        if ({if_rvalid, if_rdata} !== {1'b0, 32'hDEAD_BEEF})
            $display("FAIL fetch_hold: got rvalid=%b rdata=%h expected 0 deadbeef", if_rvalid, if_rdata);
        else n_pass++;
        idle();
    endtask

    task automatic test_contention();
        preload(12'h100, 32'hCAFE_0100);
        preload(12'h004, 32'h0BAD_F004);
        d_req = 1; d_we = 0; d_addr = 12'h100;
        if_req = 1; if_addr = 12'h004;
        tick();
        n_total++;
        if ({d_gnt, if_gnt, mem_addr} !== {2'b10, 12'h100})
            $display("FAIL cont_d_first: got d=%b if=%b addr=%h expected 1 0 100", d_gnt, if_gnt, mem_addr);
        else n_pass++;
        d_req = 0;
        tick();
        n_total++;
        if ({if_gnt, d_rvalid, d_rdata, mem_addr} !== {2'b11, 32'hCAFE_0100, 12'h004})
            $display("FAIL cont_if_second: got if=%b drv=%b drd=%h addr=%h expected 1 1 cafe0100 004", if_gnt, d_rvalid, d_rdata, mem_addr);
        else n_pass++;
        if_req = 0;
        tick();
        n_total++;
        if ({if_rvalid, d_rvalid, if_rdata} !== {2'b10, 32'h0BAD_F004})
            $display("FAIL cont_if_return: got irv=%b drv=%b ird=%h expected 1 0 0badf004", if_rvalid, d_rvalid, if_rdata);
        else n_pass++;
        idle();
    endtask

    task automatic test_starvation();
        int       exp_seq[8] = '{3, 2, 3, 2, 3, 1, 3, 2};
        logic [2:0] one = 3'b001;
        logic [2:0] exp_gnt;
        ld_req = 1; ld_addr = 12'h020; ld_wdata = 32'h5000_0000;
        d_req = 1;  d_we = 0; d_addr = 12'h030;
        if_req = 1; if_addr = 12'h040;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_gnt = one << (exp_seq[i] - 1);
            n_total++;
            if ({ld_gnt, d_gnt, if_gnt} !== exp_gnt)
                $display("FAIL starve_seq[%0d]: got ld/d/if=%b expected %b", i, {ld_gnt, d_gnt, if_gnt}, exp_gnt);
            else n_pass++;
            if (m_gnt_ld) begin ld_addr = ld_addr + 1; ld_wdata = ld_wdata + 1; end
            if (m_gnt_d)  d_addr = d_addr + 1;
        end
        idle();
    endtask

    task automatic test_write_read();
        d_req = 1; d_we = 1; d_addr = 12'h200; d_wdata = 32'h1234_5678;
        tick();
        n_total++;
        if ({d_gnt, mem_we, mem_re, mem_addr, mem_wdata} !== {3'b110, 12'h200, 32'h1234_5678})
            $display("FAIL wr_issue: got gnt=%b we=%b re=%b addr=%h wd=%h expected 1 1 0 200 12345678", d_gnt, mem_we, mem_re, mem_addr, mem_wdata);
        else n_pass++;
        d_we = 0;
        tick();
        n_total++;
        if ({d_gnt, mem_we, mem_re, d_rvalid} !== 4'b0)
            $display("FAIL wr_gap: got gnt=%b we=%b re=%b rvalid=%b expected 0 0 0 0", d_gnt, mem_we, mem_re, d_rvalid);
        else n_pass++;
        tick();
        n_total++;
        if ({d_gnt, mem_re, mem_addr} !== {2'b11, 12'h200})
            $display("FAIL rd_issue: got gnt=%b re=%b addr=%h expected 1 1 200", d_gnt, mem_re, mem_addr);
        else n_pass++;
        d_req = 0;
        tick();
        n_total++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h1234_5678})
            $display("FAIL rd_return: got rvalid=%b rdata=%h expected 1 12345678", d_rvalid, d_rdata);
        else n_pass++;
        preload(12'h300, 32'h0);
        ld_req = 1; ld_addr = 12'h300; ld_wdata = 32'h0F0F_1234;
        if_req = 1; if_addr = 12'h300;
        tick();
        ld_req = 0;
        tick();
        if_req = 0;
        tick();
        n_total++;
        if ({if_rvalid, if_rdata} !== {1'b1, 32'h0F0F_1234})
            $display("FAIL ld_then_if: got rvalid=%b rdata=%h expected 1 0f0f1234", if_rvalid, if_rdata);
        else n_pass++;
        idle();
    endtask

    task automatic test_reset_mid();
        preload(12'h050, 32'h5A5A_5050);
        ld_req = 1; ld_addr = 12'h060; ld_wdata = 32'h6060_6060;
        d_req = 1;  d_we = 0; d_addr = 12'h050;
        if_req = 1; if_addr = 12'h070;
        tick();
        n_total++;
        if ({ld_gnt, d_gnt, if_gnt} !== 3'b100)
            $display("FAIL mid_ld_first: got ld/d/if=%b expected 100", {ld_gnt, d_gnt, if_gnt});
        else n_pass++;
        ld_req = 0;
        tick();
        n_total++;
        if ({d_gnt, mem_re} !== 2'b11)
            $display("FAIL mid_d_issue: got gnt=%b re=%b expected 1 1", d_gnt, mem_re);
        else n_pass++;
        rst = 1;
        tick();
        n_total++;
        if ({if_gnt, d_gnt, ld_gnt, mem_re, mem_we, if_rvalid, d_rvalid} !== 7'b0)
            $display("FAIL mid_rst_ctrl: got %b expected 0000000", {if_gnt, d_gnt, ld_gnt, mem_re, mem_we, if_rvalid, d_rvalid});
        else n_pass++;
        n_total++;
        if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== '0)
            $display("FAIL mid_rst_data: got %h/%h/%h/%h expected all 0", if_rdata, d_rdata, mem_addr, mem_wdata);
        else n_pass++;
        rst = 0; if_req = 0; d_req = 0;
        tick();
        n_total++;
        if ({d_rvalid, if_rvalid, d_gnt} !== 3'b0)
            $display("FAIL mid_after: got drv=%b irv=%b dgnt=%b expected 0 0 0", d_rvalid, if_rvalid, d_gnt);
        else n_pass++;
        idle();
    endtask

    task automatic test_random();
        logic [6:0] got_c, exp_c;
        for (int cyc = 0; cyc < 600; cyc++) begin
            tick();
            got_c = {if_gnt, d_gnt, ld_gnt, mem_re, mem_we, if_rvalid, d_rvalid};
            exp_c = {m_gnt_if, m_gnt_d, m_gnt_ld, m_re, m_we, m_rv_if, m_rv_d};
            n_total++;
            if (got_c !== exp_c)
                $display("FAIL rand_ctrl cyc %0d: got %b expected %b", cyc, got_c, exp_c);
            else n_pass++;
            n_total++;
            if ({if_rdata, d_rdata} !== {m_rd_if, m_rd_d})
                $display("FAIL rand_rdata cyc %0d: got %h/%h expected %h/%h", cyc, if_rdata, d_rdata, m_rd_if, m_rd_d);
            else n_pass++;
            if (m_re || m_we) begin
                n_total++;
                if (mem_addr !== m_addr)
                    $display("FAIL rand_addr cyc %0d: got %h expected %h", cyc, mem_addr, m_addr);
                else n_pass++;
            end
            if (m_we) begin
                n_total++;
                if (mem_wdata !== m_wdata)
                    $display("FAIL rand_wdata cyc %0d: got %h expected %h", cyc, mem_wdata, m_wdata);
                else n_pass++;
            end
            rst = ($urandom_range(0, 79) == 0);
            if (m_gnt_if || !if_req) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = AW'($urandom_range(0, 15));
            end
            if (m_gnt_d || !d_req) begin
                d_req = ($urandom_range(0, 2) != 0);
                d_we = $urandom_range(0, 1) == 1;
                d_addr = AW'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            if (m_gnt_ld || !ld_req) begin
                ld_req = ($urandom_range(0, 3) == 0);
                ld_addr = AW'($urandom_range(0, 15));
                ld_wdata = $urandom;
            end
        end
        idle();
    endtask

    initial begin
        logic [DW-1:0] v;
        rst = 1; if_req = 0; d_req = 0; ld_req = 0; d_we = 0;
        if_addr = '0; d_addr = '0; ld_addr = '0; d_wdata = '0; ld_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = $urandom;
            preload(AW'(i), v);
        end
        #1;
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_write_read();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
